muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative RV32M multiply/divide execution unit for the multi-cycle CPU. It sits directly downstream of the instruction decoder and is launched when the decoder flags an M-extension instruction. It captures both register operands and the funct3 opcode, runs a 32-iteration shift-add multiply or restoring divide, and returns a single XLEN result to the writeback path through a start/busy/done handshake.

## Interface
- XLEN, 32, operand and result width; only 32 is supported.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  launch request; sampled only in IDLE or DONE.
- op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1  input  XLEN  operand A (multiplicand/dividend).
- rs2  input  XLEN  operand B (multiplier/divisor).
- busy  output  1  high while an operation is in flight (CALC state).
- done  output  1  one-cycle pulse; result is valid in that cycle.
- result  output  XLEN  registered result; holds until the next operation completes.

## Operation
- States: IDLE, CALC, DONE. Reset forces IDLE, busy=0, done=0, result=0, counter=0.
- IDLE/DONE with start=1: capture op, take absolute values of signed operands, record the result sign, clear the 64-bit accumulator, set counter=31, go to CALC. Otherwise DONE returns to IDLE.
- Signedness: MUL/MULH/DIV/REM treat both operands as signed. MULHSU treats rs1 as signed and rs2 as unsigned. MULHU/DIVU/REMU treat both as unsigned.
- Multiply, one bit per cycle: if the multiplier LSB is 1, add the multiplicand into the upper accumulator half, then shift right. After 32 cycles, negate the 64-bit product if the result sign is negative. MUL returns bits [31:0]; MULH/MULHSU/MULHU return bits [63:32].
- Divide, restoring, one quotient bit per cycle, MSB first: shift the remainder left and bring in the next dividend bit. If remainder ≥ |divisor|, subtract it and set the quotient bit. After 32 cycles:
  - negate the quotient if the operand signs differ (DIV only);
  - negate the remainder if the dividend is negative (REM only).
- Divide by zero: quotient = 0xFFFFFFFF; remainder = rs1 unchanged.
- Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF, DIV/REM): quotient = 0x80000000; remainder = 0.
- CALC exit: when counter reaches 0, the final result is written to `result` and the state goes to DONE.
- start is ignored while in CALC. Operand or op changes during CALC have no effect.
- Reset mid-operation aborts immediately with the reset values above. No done pulse is produced for the aborted operation.

## Timing
- Accepting edge E0 (start=1 in IDLE/DONE): busy=1 from E0 through E32.
- At E32: busy=0, done=1, result updated. At E33: done=0, unless start was sampled at E32, in which case busy=1 again.
- Normal latency: 32 cycles from the accepting edge to the done cycle.
- Back-to-back operation: start asserted during the done cycle is accepted at that edge, with no idle bubble.
- result changes only on the edge that enters DONE.

## Configuration
- MULDIV_EARLY_OUT_EN defined:
  - divide by zero and signed overflow skip CALC; the edge after E0 enters DONE with the special-case result (done at E1, busy never asserted);
  - a multiply with either operand zero also completes at E1 with result 0.
- Undefined: every operation takes the full 32 iterations. Special-case results are identical; only latency differs.

## Test plan
- MUL rs1=0xFFFFFFFD (−3), rs2=7 → result 0xFFFFFFEB, done exactly 32 cycles after start, busy high for 32 cycles.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 7/2 → 3; REMU 7/2 → 1.
- DIV x/0 → 0xFFFFFFFF and REM x/0 → x. DIV 0x80000000/−1 → 0x80000000, REM → 0. Latency is 1 cycle with MULDIV_EARLY_OUT_EN defined, 32 without.
- start pulsed at cycle 10 of CALC → ignored, result unchanged. Back-to-back start during done → second op accepted, no idle cycle.
- rst_n low at cycle 15 of CALC → busy=0, done=0, result=0 immediately. A new start afterwards completes correctly.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - start/busy/done handshake bundle between the decoder and the RV32M multiply/divide unit
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, op, rs1, rs2,
    input  busy, done, result
  );

  modport slave (
    input  start, op, rs1, rs2,
    output busy, done, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit; MULDIV_EARLY_OUT_EN enables single-cycle special cases
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input logic          clk,
  input logic          rst_n,
  muldiv_unit_if.slave bus
);

`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY_OUT = 1'b1;
`else
  localparam bit EARLY_OUT = 1'b0;
`endif

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state;
  logic [4:0]        count;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   a_q;          // multiplicand, or divisor magnitude
  logic [XLEN-1:0]   b_q;          // multiplier shifting right, or dividend shifting left
  logic [2:0]        op_q;
  logic              neg_q;        // sign to apply to the selected result
  logic              special_q;
  logic [XLEN-1:0]   special_val;
  logic              busy_q;
  logic              done_q;
  logic [XLEN-1:0]   result_q;

  logic              a_signed, b_signed, a_neg, b_neg, is_div;
  logic              div_zero, div_ovf, special_hit, neg_in;
  logic [XLEN-1:0]   a_abs, b_abs, special_in;

  // Launch decode: operand magnitudes, result sign and special-case detection
  always_comb begin
    is_div   = bus.op[2];
    a_signed = !(bus.op == 3'b011 || bus.op == 3'b101 || bus.op == 3'b111);
    b_signed = !(bus.op == 3'b010 || bus.op == 3'b011 || bus.op == 3'b101 || bus.op == 3'b111);
    a_neg    = a_signed & bus.rs1[XLEN-1];
    b_neg    = b_signed & bus.rs2[XLEN-1];
    a_abs    = a_neg ? (~bus.rs1 + 1'b1) : bus.rs1;
    b_abs    = b_neg ? (~bus.rs2 + 1'b1) : bus.rs2;
    // REM follows the dividend sign; DIV and the multiplies follow the sign product
    neg_in   = (bus.op[2] & bus.op[1]) ? a_neg : (a_neg ^ b_neg);
    div_zero = is_div && (bus.rs2 == '0);
    div_ovf  = is_div && !bus.op[0] && (bus.rs1 == MIN_NEG) && (bus.rs2 == '1);
    special_hit = div_zero | div_ovf;
    if (div_zero)
      special_in = bus.op[1] ? bus.rs1 : '1;
    else
      special_in = bus.op[1] ? '0 : MIN_NEG;
`ifdef MULDIV_EARLY_OUT_EN
    // A zero multiply operand yields zero; only worth flagging when it saves cycles
    if (!is_div && (bus.rs1 == '0 || bus.rs2 == '0)) begin
      special_hit = 1'b1;
      special_in  = '0;
    end
`endif
  end

  logic [XLEN:0]     mul_sum, rem_ext;
  logic              rem_ge;
  logic [XLEN-1:0]   rem_sub;
  logic [2*XLEN-1:0] acc_next, prod;
  logic [XLEN-1:0]   quo, rem, final_val;

  // One iteration of shift-add multiply or restoring divide, plus final sign fix-up
  always_comb begin
    mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (b_q[0] ? {1'b0, a_q} : {(XLEN+1){1'b0}});
    // Remainder can reach 2*divisor-1 after the shift, so compare at XLEN+1 bits
    rem_ext = {acc[2*XLEN-1:XLEN], b_q[XLEN-1]};
    rem_ge  = rem_ext >= {1'b0, a_q};
    rem_sub = rem_ext[XLEN-1:0] - a_q;
    if (op_q[2])
      acc_next = {(rem_ge ? rem_sub : rem_ext[XLEN-1:0]), acc[XLEN-2:0], rem_ge};
    else
      acc_next = {mul_sum, acc[XLEN-1:1]};
    prod = neg_q ? (~acc_next + 1'b1) : acc_next;
    quo  = acc_next[XLEN-1:0];
    rem  = acc_next[2*XLEN-1:XLEN];
    if (special_q)
      final_val = special_val;
    else if (op_q[2])
      final_val = op_q[1] ? (neg_q ? (~rem + 1'b1) : rem) : (neg_q ? (~quo + 1'b1) : quo);
    else if (op_q[1:0] == 2'b00)
      final_val = prod[XLEN-1:0];
    else
      final_val = prod[2*XLEN-1:XLEN];
  end

  // Control FSM with registered busy/done/result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= '0;
      acc         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      neg_q       <= 1'b0;
      special_q   <= 1'b0;
      special_val <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            op_q        <= bus.op;
            neg_q       <= neg_in;
            special_q   <= special_hit;
            special_val <= special_in;
            acc         <= '0;
            a_q         <= is_div ? b_abs : a_abs;
            b_q         <= is_div ? a_abs : b_abs;
            state       <= CALC;
            // Early-out passes through CALC for one cycle with busy held low
            if (EARLY_OUT && special_hit) begin
              count  <= 5'd0;
              busy_q <= 1'b0;
            end else begin
              count  <= 5'd31;
              busy_q <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          acc   <= acc_next;
          b_q   <= op_q[2] ? (b_q << 1) : (b_q >> 1);
          count <= count - 5'd1;
          if (count == 5'd0) begin
            state    <= DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= final_val;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
module tb_muldiv_unit;
  localparam int XLEN = 32;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int SPEC_LAT = 1;
`else
  localparam int SPEC_LAT = 32;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  muldiv_unit_if #(.XLEN(XLEN)) mif ();

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (mif.slave)
  );

  always #5 clk = ~clk;

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat, input string name);
    int n;
    int busy_cnt;
    int exp_busy;
    exp_busy = (exp_lat == 1) ? 0 : 32;
    mif.start = 1'b1; mif.op = op; mif.rs1 = a; mif.rs2 = b;
    @(posedge clk); #1;
    mif.start = 1'b0;
    n = 0;
    busy_cnt = mif.busy ? 1 : 0;
    while (!mif.done && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (!mif.done && mif.busy) busy_cnt++;
    end
    checks++;
    if (mif.result !== exp) begin
      errors++; $display("FAIL %s result: got %h expected %h", name, mif.result, exp);
    end
    checks++;
    if (n !== exp_lat) begin
      errors++; $display("FAIL %s latency: got %0d expected %0d", name, n, exp_lat);
    end
    checks++;
    if (busy_cnt !== exp_busy) begin
      errors++; $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_cnt, exp_busy);
    end
    @(posedge clk); #1;
    checks++;
    if (mif.done !== 1'b0 || mif.busy !== 1'b0) begin
      errors++; $display("FAIL %s after_done: got done=%b busy=%b expected 0 0", name, mif.done, mif.busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (mif.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", mif.busy); end
    checks++;
    if (mif.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", mif.done); end
    checks++;
    if (mif.result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 0", mif.result); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (mif.busy !== 1'b0 || mif.done !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: got busy=%b done=%b expected 0 0", mif.busy, mif.done);
    end
  endtask

  task automatic test_multiply();
    run_op(3'b000, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFEB, 32, "mul_neg3x7");
    run_op(3'b001, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32, "mulh_neg3x7");
    run_op(3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 32, "mulh_min_sq");
    run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32, "mulhu_max_sq");
    run_op(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32, "mulhsu_m1xmax");
    run_op(3'b000, 32'h00010000, 32'h00010001, 32'h00010000, 32, "mul_lo_carry");
    run_op(3'b011, 32'h00010000, 32'h00010001, 32'h00000001, 32, "mulhu_hi_carry");
    run_op(3'b000, 32'h00000000, 32'h00001234, 32'h00000000, SPEC_LAT, "mul_zero_a");
    run_op(3'b011, 32'h00001234, 32'h00000000, 32'h00000000, SPEC_LAT, "mulhu_zero_b");
  endtask

  task automatic test_divide();
    run_op(3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32, "div_neg7_2");
    run_op(3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32, "rem_neg7_2");
    run_op(3'b101, 32'd7,        32'd2,        32'd3,        32, "divu_7_2");
    run_op(3'b111, 32'd7,        32'd2,        32'd1,        32, "remu_7_2");
    run_op(3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32, "div_7_neg2");
    run_op(3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        32, "rem_7_neg2");
    run_op(3'b101, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32, "divu_max_1");
    run_op(3'b111, 32'hFFFFFFFF, 32'h10,       32'h0000000F, 32, "remu_max_16");
    run_op(3'b101, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32, "divu_min_max");
    run_op(3'b111, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32, "remu_min_max");
  endtask

  task automatic test_special();
    run_op(3'b100, 32'h12345678, 32'h0,        32'hFFFFFFFF, SPEC_LAT, "div_by_zero");
    run_op(3'b110, 32'h12345678, 32'h0,        32'h12345678, SPEC_LAT, "rem_by_zero");
    run_op(3'b100, 32'hFFFFFFFB, 32'h0,        32'hFFFFFFFF, SPEC_LAT, "div_neg_by_zero");
    run_op(3'b110, 32'hFFFFFFFB, 32'h0,        32'hFFFFFFFB, SPEC_LAT, "rem_neg_by_zero");
    run_op(3'b101, 32'h12345678, 32'h0,        32'hFFFFFFFF, SPEC_LAT, "divu_by_zero");
    run_op(3'b111, 32'h12345678, 32'h0,        32'h12345678, SPEC_LAT, "remu_by_zero");
    run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, SPEC_LAT, "div_overflow");
    run_op(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, SPEC_LAT, "rem_overflow");
  endtask

  task automatic test_ignore_start();
    int n;
    run_op(3'b111, 32'd7, 32'd2, 32'd1, 32, "ign_pre_remu");
    mif.start = 1'b1; mif.op = 3'b000; mif.rs1 = 32'hFFFFFFFD; mif.rs2 = 32'd7;
    @(posedge clk); #1;
    mif.start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    checks++;
    if (mif.result !== 32'd1 || mif.busy !== 1'b1) begin
      errors++; $display("FAIL ign_mid_calc: got result=%h busy=%b expected 00000001 1", mif.result, mif.busy);
    end
    mif.start = 1'b1; mif.op = 3'b101; mif.rs1 = 32'd9; mif.rs2 = 32'd3;
    @(posedge clk); #1;
    mif.start = 1'b0;
    n = 11;
    while (!mif.done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n !== 32) begin errors++; $display("FAIL ign_latency: got %0d expected 32", n); end
    checks++;
    if (mif.result !== 32'hFFFFFFEB) begin
      errors++; $display("FAIL ign_result: got %h expected FFFFFFEB", mif.result);
    end
    @(posedge clk); #1;
    checks++;
    if (mif.busy !== 1'b0 || mif.done !== 1'b0) begin
      errors++; $display("FAIL ign_no_relaunch: got busy=%b done=%b expected 0 0", mif.busy, mif.done);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    mif.start = 1'b1; mif.op = 3'b101; mif.rs1 = 32'd100; mif.rs2 = 32'd7;
    @(posedge clk); #1;
    mif.start = 1'b0;
    n = 0;
    while (!mif.done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n !== 32 || mif.result !== 32'd14) begin
      errors++; $display("FAIL b2b_first: got lat=%0d result=%h expected 32 0000000E", n, mif.result);
    end
    mif.start = 1'b1; mif.op = 3'b111; mif.rs1 = 32'd100; mif.rs2 = 32'd7;
    @(posedge clk); #1;
    mif.start = 1'b0;
    checks++;
    if (mif.busy !== 1'b1 || mif.done !== 1'b0) begin
      errors++; $display("FAIL b2b_no_bubble: got busy=%b done=%b expected 1 0", mif.busy, mif.done);
    end
    checks++;
    if (mif.result !== 32'd14) begin
      errors++; $display("FAIL b2b_result_hold: got %h expected 0000000E", mif.result);
    end
    n = 0;
    while (!mif.done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n !== 32 || mif.result !== 32'd2) begin
      errors++; $display("FAIL b2b_second: got lat=%0d result=%h expected 32 00000002", n, mif.result);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    mif.start = 1'b1; mif.op = 3'b000; mif.rs1 = 32'hFFFFFFFD; mif.rs2 = 32'd7;
    @(posedge clk); #1;
    mif.start = 1'b0;
    repeat (15) begin @(posedge clk); #1; end
    checks++;
    if (mif.busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_before: got %b expected 1", mif.busy); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (mif.busy !== 1'b0 || mif.done !== 1'b0 || mif.result !== 32'h0) begin
      errors++; $display("FAIL rmid_abort: got busy=%b done=%b result=%h expected 0 0 0", mif.busy, mif.done, mif.result);
    end
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if (mif.done !== 1'b0 || mif.busy !== 1'b0) begin
      errors++; $display("FAIL rmid_no_done: got busy=%b done=%b expected 0 0", mif.busy, mif.done);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(3'b101, 32'd100, 32'd7, 32'd14, 32, "rmid_after_divu");
  endtask

  initial begin
    mif.start = 1'b0; mif.op = 3'b000; mif.rs1 = '0; mif.rs2 = '0;
    test_reset();
    test_multiply();
    test_divide();
    test_special();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
